bcd_scan_counter: RTL

- Two-digit BCD up/down counter with run/stop control and an integrated display-scan generator.
- Sits directly upstream of the two-digit SSD select/mux stage:
  - digit_ones drives the mux "a" input (rightmost digit).
  - digit_tens drives the mux "b" input.
  - scan_en drives the mux enable.
- Counts 00–99 with wrap-around. Counting advances once per CNT_DIV clocks while in RUN.

---
 rtl/bcd_scan_counter_pkg.sv | 50 +++++
 rtl/bcd_scan_counter_tick_gen.sv | 43 ++++
 rtl/bcd_scan_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// ----------------------------------------------------------------------------
// bcd_scan_counter_pkg
//   Shared definitions for the two-digit display path: BCD digit width and
//   limit, the run/stop state encoding, the scan-select polarity shared with
//   the downstream SSD select stage, and the two-digit BCD step function.
// ----------------------------------------------------------------------------
package bcd_scan_counter_pkg;

    localparam int           BCD_W   = 4;
    localparam logic [3:0]   BCD_MAX = 4'd9;

    // scan_en level that makes the SSD select stage show the ones digit
    localparam logic SSD_SEL_ONES = 1'b1;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // One count step on a two-digit BCD value, wrapping 99<->00.
    // Any non-BCD digit (only reachable by forcing) collapses to 00.
    function automatic bcd2_t bcd_next(input bcd2_t cur, input logic up);
        bcd2_t nxt;
        nxt = cur;
        if (cur.ones > BCD_MAX || cur.tens > BCD_MAX) begin
            nxt = '0;
        end else if (up) begin
            if (cur.ones == BCD_MAX) begin
                nxt.ones = '0;
                nxt.tens = (cur.tens == BCD_MAX) ? '0 : cur.tens + 4'd1;
            end else begin
                nxt.ones = cur.ones + 4'd1;
            end
        end else begin
            if (cur.ones == '0) begin
                nxt.ones = BCD_MAX;
                nxt.tens = (cur.tens == '0) ? BCD_MAX : cur.tens - 4'd1;
            end else begin
                nxt.ones = cur.ones - 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
//   Modulo-DIV enable divider. The counter advances only while en is high and
//   holds otherwise, so a paused count resumes where it stopped. pulse is high
//   (combinationally) on the last count of each period; the parent registers
//   it. clr zeroes the counter and suppresses that cycle's pulse.
//
//   Ports:
//     clk   in  system clock
//     rst   in  synchronous active-high reset
//     en    in  count enable
//     clr   in  synchronous counter clear
//     pulse out period-complete strobe (en && !clr && cnt == DIV-1)
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    // DIV == 1 still needs a 1-bit counter; it simply never leaves 0
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          at_last;

    assign at_last = (cnt == LAST);
    assign pulse   = en & ~clr & at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// ----------------------------------------------------------------------------
// bcd_scan_counter
//   Two-digit BCD up/down counter with run/stop control and a display-scan
//   generator feeding the two-digit SSD select/mux stage.
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset (highest priority)
//     start_stop  in   one-cycle pulse, toggles RUN/STOP
//     clr         in   level, clears digits and count divider (keeps state)
//     dir         in   1 = up, 0 = down; sampled on the step cycle
//     digit_ones  out  BCD ones digit (mux "a")
//     digit_tens  out  BCD tens digit (mux "b")
//     scan_en     out  1 = show ones, 0 = show tens (mux enable)
//     running     out  1 while in RUN
//     tick        out  one-cycle pulse when new digits become visible
// ----------------------------------------------------------------------------
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int CNT_DIV  = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             clr,
    input  logic             dir,
    output logic [BCD_W-1:0] digit_ones,
    output logic [BCD_W-1:0] digit_tens,
    output logic             scan_en,
    output logic             running,
    output logic             tick
);

    state_t state;
    logic   step;
    logic   scan_pulse;
    bcd2_t  cur;
    bcd2_t  nxt;

    // Count divider: paused (not reset) while stopped, cleared by clr.
    // Its enable is the registered running flag, which equals state == RUN.
    tick_gen #(.DIV(CNT_DIV)) u_cnt_div (
        .clk   (clk),
        .rst   (rst),
        .en    (running),
        .clr   (clr),
        .pulse (step)
    );

    // Scan divider: free-running, independent of run state and clr
    tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .clr   (1'b0),
        .pulse (scan_pulse)
    );

    assign cur = '{tens: digit_tens, ones: digit_ones};
    assign nxt = bcd_next(cur, dir);

    // step is already masked by clr inside the divider, so tick stays low on
    // a clear cycle. A start_stop coinciding with step still lets the step
    // land because the digit update does not look at start_stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STOP;
            running    <= 1'b0;
            digit_ones <= '0;
            digit_tens <= '0;
            tick       <= 1'b0;
            scan_en    <= SSD_SEL_ONES;
        end else begin
            if (scan_pulse) begin
                scan_en <= ~scan_en;
            end

            if (start_stop) begin
                state   <= (state == RUN) ? STOP : RUN;
                running <= (state == STOP);
            end

            tick <= step;

            if (clr) begin
                digit_ones <= '0;
                digit_tens <= '0;
            end else if (step) begin
                digit_ones <= nxt.ones;
                digit_tens <= nxt.tens;
            end
        end
    end

endmodule
